// File: rtl/collision_scan.sv
// ---------------------------------------------------------------------------
// collision_scan
//
// Read-side consumer of the shared object table. A frame tick (start) freezes
// a copy of the whole table plus the player box, then the FSM walks the copy
// one slot per cycle. Each enemy slot is tested for strict AABB overlap with
// the player box; hits build a per-slot mask, a hit count and a sticky
// game-over flag.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      frame tick, accepted only while idle
//   gamedata   object table, slot i at [i*DATALEN +: DATALEN]
//   player_x/y player box origin
//   player_w/h player box size
//   clear      clears gameover (a hit on the same edge wins)
//   busy       scan in progress
//   done       one-cycle pulse, hit_mask/hit_count final
//   hit_mask   bit i set when slot i collided in the last scan
//   hit_count  population count of hit_mask
//   gameover   sticky collision flag
// ---------------------------------------------------------------------------

// Per-slot overlap test. Pure combinational; the scanner time-multiplexes a
// single instance over the frozen table.
module cs_aabb #(
  parameter int                 DATALEN    = 44,
  parameter int                 TYPE_W     = 4,
  parameter int                 X_W        = 10,
  parameter int                 Y_W        = 10,
  parameter int                 W_W        = 10,
  parameter int                 H_W        = 10,
  parameter logic [TYPE_W-1:0]  ENEMY_TYPE = 4'd1
)(
  input  logic [DATALEN-1:0] slot,
  input  logic [X_W-1:0]     px,
  input  logic [Y_W-1:0]     py,
  input  logic [W_W-1:0]     pw,
  input  logic [H_W-1:0]     ph,
  output logic               hit
);
  // Field offsets, LSB-first: type, x, y, width, height.
  localparam int X_LO = TYPE_W;
  localparam int Y_LO = X_LO + X_W;
  localparam int W_LO = Y_LO + Y_W;
  localparam int H_LO = W_LO + W_W;

  // Extent sums carry one extra bit so box ends past the screen edge never
  // wrap back into range.
  localparam int XS = ((X_W > W_W) ? X_W : W_W) + 1;
  localparam int YS = ((Y_W > H_W) ? Y_W : H_W) + 1;

  logic [TYPE_W-1:0] e_type;
  logic [X_W-1:0]    e_x;
  logic [Y_W-1:0]    e_y;
  logic [W_W-1:0]    e_w;
  logic [H_W-1:0]    e_h;

  assign e_type = slot[TYPE_W-1:0];
  assign e_x    = slot[X_LO +: X_W];
  assign e_y    = slot[Y_LO +: Y_W];
  assign e_w    = slot[W_LO +: W_W];
  assign e_h    = slot[H_LO +: H_W];

  logic [XS-1:0] px_end, ex_end;
  logic [YS-1:0] py_end, ey_end;

  assign px_end = XS'(px)  + XS'(pw);
  assign ex_end = XS'(e_x) + XS'(e_w);
  assign py_end = YS'(py)  + YS'(ph);
  assign ey_end = YS'(e_y) + YS'(e_h);

  // Strict compares: shared edges and zero-size boxes do not overlap.
  logic ov_x, ov_y;
  assign ov_x = (XS'(e_x) < px_end) && (XS'(px) < ex_end);
  assign ov_y = (YS'(e_y) < py_end) && (YS'(py) < ey_end);

  assign hit = (e_type == ENEMY_TYPE) && ov_x && ov_y;
endmodule

module collision_scan #(
  parameter int                 NSLOT      = 9,
  parameter int                 DATALEN    = 44,
  parameter int                 TYPE_W     = 4,
  parameter int                 X_W        = 10,
  parameter int                 Y_W        = 10,
  parameter int                 W_W        = 10,
  parameter int                 H_W        = 10,
  parameter logic [TYPE_W-1:0]  ENEMY_TYPE = 4'd1,
  parameter int                 IDX_W      = $clog2(NSLOT),
  parameter int                 CNT_W      = $clog2(NSLOT + 1)
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [NSLOT*DATALEN-1:0] gamedata,
  input  logic [X_W-1:0]           player_x,
  input  logic [Y_W-1:0]           player_y,
  input  logic [W_W-1:0]           player_w,
  input  logic [H_W-1:0]           player_h,
  input  logic                     clear,
  output logic                     busy,
  output logic                     done,
  output logic [NSLOT-1:0]         hit_mask,
  output logic [CNT_W-1:0]         hit_count,
  output logic                     gameover
);
  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  state_t state, state_nxt;

  // Frozen copy of the table and player box; the live inputs may change
  // under us while the mover updates the table.
  logic [NSLOT-1:0][DATALEN-1:0] snap;
  logic [X_W-1:0]                snap_px;
  logic [Y_W-1:0]                snap_py;
  logic [W_W-1:0]                snap_pw;
  logic [H_W-1:0]                snap_ph;
  logic [IDX_W-1:0]              idx;

  logic capture, eval, last, slot_hit;

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    eval      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture   = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        // start is deliberately not looked at here: no restart, no queue.
        eval = 1'b1;
        if (idx == IDX_W'(NSLOT - 1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == SCAN);

  // -------------------------------------------------------------------------
  // Overlap test on the currently indexed snapshot slot
  // -------------------------------------------------------------------------
  cs_aabb #(
    .DATALEN    (DATALEN),
    .TYPE_W     (TYPE_W),
    .X_W        (X_W),
    .Y_W        (Y_W),
    .W_W        (W_W),
    .H_W        (H_W),
    .ENEMY_TYPE (ENEMY_TYPE)
  ) u_aabb (
    .slot (snap[idx]),
    .px   (snap_px),
    .py   (snap_py),
    .pw   (snap_pw),
    .ph   (snap_ph),
    .hit  (slot_hit)
  );

  // -------------------------------------------------------------------------
  // Snapshot, index and results
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap      <= '0;
      snap_px   <= '0;
      snap_py   <= '0;
      snap_pw   <= '0;
      snap_ph   <= '0;
      idx       <= '0;
      done      <= 1'b0;
      hit_mask  <= '0;
      hit_count <= '0;
    end else begin
      done <= last;
      if (capture) begin
        snap      <= gamedata;
        snap_px   <= player_x;
        snap_py   <= player_y;
        snap_pw   <= player_w;
        snap_ph   <= player_h;
        idx       <= '0;
        hit_mask  <= '0;
        hit_count <= '0;
      end else begin
        if (eval && !last)
          idx <= idx + 1'b1;
        if (eval && slot_hit) begin
          hit_mask[idx] <= 1'b1;
          hit_count     <= hit_count + 1'b1;
        end
      end
    end
  end

  // Sticky flag: a hit on the same edge as clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                gameover <= 1'b0;
    else if (eval && slot_hit) gameover <= 1'b1;
    else if (clear)            gameover <= 1'b0;
  end
endmodule

// File: doc/collision_scan.md
# collision_scan

Read-side consumer of the shared object table that the enemy spawner/mover writes. On each frame tick it snapshots the 9-slot table and walks it one slot per cycle. Every slot typed as an enemy gets an axis-aligned bounding-box overlap test against the player box. It reports the per-slot hit mask, the hit count and a sticky game-over flag to the game-control logic.

## Interface
- NSLOT, 9, number of object slots
- DATALEN, 44, bits per slot
- TYPE_W / X_W / Y_W / W_W / H_W, 4 / 10 / 10 / 10 / 10, field widths; fields packed LSB-first: type [3:0], x [13:4], y [23:14], width [33:24], height [43:34]
- ENEMY_TYPE, 4'd1, type code tested; 0 = empty slot
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  frame tick, one-cycle pulse; begins a scan when idle
- gamedata  in  NSLOT*DATALEN  object table; slot i at [i*DATALEN +: DATALEN]
- player_x, player_y  in  10 each  player box origin
- player_w, player_h  in  10 each  player box size
- clear  in  1  clears gameover (restart)
- busy  out  1  scan in progress
- done  out  1  one-cycle pulse; results valid
- hit_mask  out  NSLOT  bit i = slot i collided in last scan
- hit_count  out  4  number of set bits in hit_mask
- gameover  out  1  sticky collision flag

## Operation
- Reset (async, rst_n=0): state IDLE, busy=0, done=0, hit_mask=0, hit_count=0, gameover=0, index=0, snapshot regs=0.
- FSM: IDLE, SCAN.
- IDLE: on start=1 -> capture gamedata and player_x/y/w/h into snapshot regs, clear hit_mask and hit_count, index=0, go SCAN.
- SCAN: each cycle evaluates slot[index] from the snapshot only. Changes on the live gamedata/player inputs during a scan are invisible.
- Slot hits iff type==ENEMY_TYPE and ex<px+pw and px<ex+ew and ey<py+ph and py<ey+eh.
  - Sums are computed at 11 bits (no wrap).
  - Comparisons are strict: touching edges or zero width/height never hit.
- On hit: hit_mask[index]<=1, hit_count<=hit_count+1, gameover<=1.
- index==NSLOT-1: go IDLE, pulse done; otherwise index<=index+1.
- start while in SCAN: ignored (no restart, no queue).
- clear=1: gameover<=0, unless a hit is recorded on the same edge (set wins). clear does not touch hit_mask/hit_count.
- Non-enemy nonzero types (player, scenery) are skipped regardless of overlap.

## Timing
- Start sampled at edge E0. busy=1 from after E0 until after E9 (exactly 9 cycles).
- Slot k is evaluated at edge E(k+1); hit_mask/hit_count/gameover update at that edge.
- done=1 for the single cycle after E9. hit_mask/hit_count are final then and held until the next accepted start.
- A start in the done cycle is accepted (state already IDLE): scans back-to-back every 10 cycles.
- rst_n low mid-scan aborts immediately to reset values. The scan does not resume after release.

## Test plan
- Reset: rst_n=0 with start pulsing -> busy=0, done=0, hit_mask=0, hit_count=0, gameover=0 throughout. After release, no activity until start.
- Single hit:
  - Stimulus: slot 3 = enemy x=100 y=50 w=20 h=20; player 110,60,16,16; start.
  - Response: busy 9 cycles, done the cycle after E9, hit_mask=9'h008, hit_count=1, gameover=1 from E4.
- Boundaries:
  - Stimulus: enemy x=126 vs player x=110 w=16 (touching); slot 5 enemy w=0 overlapping player.
  - Response: hit_mask=0, gameover=0.
- Type filter: slots 0..8 all overlap the player, types 0,1,2,1,0,3,1,0,1 -> hit_mask=9'b101001010, hit_count=4.
- Snapshot/ignore:
  - Stimulus: start with slot 8 overlapping; at E3 clear slot 8 in gamedata and pulse start.
  - Response: no restart, hit_mask[8]=1, done exactly once.
- Reset/clear:
  - rst_n low at E5 of a hitting scan -> all outputs 0, no done.
  - clear on the same edge as a hit -> gameover stays 1; clear alone -> gameover 0.
